// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: multi-cycle wide adder that pushes one nibble per clock
// through a single 4-bit carry-lookahead slice, LSB nibble first, with the
// nibble carry-out registered and fed back as the next nibble's carry-in.
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB = WIDTH / 4;
  localparam int KW  = $clog2(NIB);
  localparam logic [KW-1:0] LAST = KW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             accept;
  logic             last;
  logic [KW-1:0]    k;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [3:0]       p;
  logic [3:0]       g;
  logic [3:0]       c;
  logic [3:0]       s;

  assign a_nib = a_reg[{k, 2'b00} +: 4];
  assign b_nib = b_reg[{k, 2'b00} +: 4];

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; a start is honoured in IDLE and DONE so results can chain.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (k == LAST) begin
          last       = 1'b1;
          next_state = DONE;
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end else begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // 4-bit carry-lookahead slice on the current nibble, seeded by the carry register.
  always_comb begin
    p    = a_nib ^ b_nib;
    g    = a_nib & b_nib;
    c[0] = g[0] | (p[0] & carry);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & carry);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & carry);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & carry);
    s    = p ^ {c[2:0], carry};
  end

  // Operand capture on accept, then one nibble of sum per RUN cycle; flags land on the last nibble.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      k     <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      a_reg <= a;
      b_reg <= b;
      carry <= cin;
      k     <= '0;
      sum   <= '0;
    end else if (busy) begin
      sum[{k, 2'b00} +: 4] <= s;
      carry <= c[3];
      if (last) begin
        k    <= '0;
        cout <= c[3];
        ovf  <= c[2] ^ c[3];
      end else begin
        k <= k + 1'b1;
      end
    end
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
Multi-cycle wide adder that drives our 4-bit carry-lookahead slice one nibble per clock, LSB nibble first.
- The carry out of each nibble is registered and fed back as carry-in to the next nibble.
- Sits upstream of (and wraps) the 4-bit CLA datapath, so operands wider than 4 bits go through a single 4-bit slice.
- Start/done handshake toward the controlling logic.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 8.
NIB, WIDTH/4, derived nibble count; not overridable.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous, active-high reset.
start  input  1  request; sampled only when busy=0.
a  input  WIDTH  operand A; captured on accepted start.
b  input  WIDTH  operand B; captured on accepted start.
cin  input  1  carry into bit 0; captured on accepted start.
busy  output  1  high while in RUN.
done  output  1  one-cycle pulse when sum/cout/ovf become valid.
sum  output  WIDTH  result, registered.
cout  output  1  carry out of bit WIDTH-1, registered.
ovf  output  1  signed overflow, registered.

Behaviour:
- Reset:
  - Outputs: busy=0, done=0, sum=0, cout=0, ovf=0.
  - Internal state: state=IDLE, nibble index k=0, carry register=0, operand registers=0.
  - rst has priority over every other input, including while in RUN: the operation is aborted and no done is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1: latch a, b, cin; clear k; clear the sum register. Next state RUN.
  - Otherwise stay in IDLE; sum/cout/ovf hold their last values.
- RUN (busy=1), on each edge:
  - Nibble k: s = A[4k+3:4k] + B[4k+3:4k] + carry, computed with 4-bit lookahead logic (p=a^b, g=a&b, c[i]=g[i]|p[i]&c[i-1]).
  - sum[4k+3:4k] <= s.
  - carry <= c[3]; k <= k+1.
  - When k=NIB-1: cout <= c[3]; ovf <= c[2]^c[3] (carry into MSB xor carry out); next state DONE.
  - start is ignored while in RUN.
- DONE:
  - done=1 for exactly one cycle; busy=0.
  - Next state IDLE.
  - start=1 in DONE is accepted as in IDLE (latch operands, next state RUN). This allows back-to-back operations with no idle cycle.
- Latency: start accepted at edge T gives done=1 in the cycle following edge T+NIB (done visible NIB+1 cycles after the accept). With WIDTH=16, done is high in cycle T+5.
- Throughput: one result per NIB+1 cycles when back-to-back.
- Output stability:
  - Upper sum nibbles are partial or zero while busy=1.
  - sum/cout/ovf are valid from the done cycle and held until the next accepted start clears sum.
- Operand isolation: a/b/cin may change freely after the accept cycle; only the latched copies are used.
- Arithmetic: unsigned modulo 2^WIDTH; cout is the unsigned carry; ovf uses the two's-complement interpretation. No saturation.

Test Plan:
1. a=0x1234, b=0x4321, cin=0, pulse start -> after 5 cycles done=1 for one cycle, sum=0x5555, cout=0, ovf=0; busy high exactly 4 cycles.
2. a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
3. a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1. Then a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1, ovf=1.
4. Start 0x0F0F+0x00F1; hold start=1 with different a/b during RUN -> result 0x1000, cout=0, and changed inputs are ignored. Assert start in the DONE cycle with 0x0001+0x0001 -> second done exactly 5 cycles after the first, sum=0x0002.
5. Start 0xAAAA+0x5555; assert rst for one cycle at the 2nd RUN cycle -> busy=0, sum=0, no done pulse. A new start then 0x0001+0x0002 -> sum=0x0003.
6. Random sweep, 1000 operand/cin triples, WIDTH=16 and WIDTH=8 -> {cout,sum} equals a+b+cin and ovf matches the reference signed-overflow rule.
